memory_port_scheduler: RTL

MEMORY_PORT_SCHEDULER -- requirements
Module: memory_port_scheduler

---
 rtl/memory_port_scheduler.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/memory_port_scheduler.sv
// Three-requester round-robin scheduler for a single Wishbone-style memory port.
// One transaction is in flight at a time. It ends on a memory ack, on a wait
// timeout, or when the owner abandons its cycle. The owner's signals are muxed
// straight through to the memory port, and the ack/error is routed back to it.
module memory_port_scheduler #(
    parameter int WORD_SIZE      = 256,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2:0]              req_cyc_i,
    input  logic [2:0]              req_stb_i,
    input  logic [2:0]              req_we_i,
    input  logic [3*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [3*WORD_SIZE-1:0]  req_mosi_i,
    output logic [2:0]              req_ack_o,
    output logic [2:0]              req_err_o,
    output logic [3*WORD_SIZE-1:0]  req_miso_o,
    output logic [2:0]              grant_o,
    output logic                    memory_cyc_o,
    output logic                    memory_stb_o,
    output logic                    memory_we_o,
    output logic [ADDR_WIDTH-1:0]   memory_addr_o,
    output logic [WORD_SIZE-1:0]    memory_mosi_o,
    input  logic                    memory_ack_i,
    input  logic [WORD_SIZE-1:0]    memory_miso_i
);

    typedef enum logic {IDLE, BUSY} state_t;

    // Wait-counter value at which an unacknowledged transaction is given up.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [2:0]  grant_q, grant_d;
    logic [1:0]  gidx_q, gidx_d;
    logic [1:0]  last_q, last_d;
    logic [15:0] wait_q, wait_d;

    logic [2:0]  pending;
    logic        busy;
    logic        cyc_held;
    logic        ack_hit;
    logic        timeout_hit;
    logic        abandon;

    // Round-robin search: last+1, last+2, then last itself (mod 3).
    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] pend);
        logic [1:0] cand;
        logic [1:0] pick;
        logic       found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            cand = 2'((int'(last) + k) % 3);
            if (!found && pend[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign pending  = req_cyc_i & req_stb_i;
    assign busy     = (state_q == BUSY);
    assign cyc_held = |(req_cyc_i & grant_q);

    // The ack takes priority over both timeout and abandonment. A dropped cycle
    // suppresses the timeout error, because that requester is no longer waiting.
    assign ack_hit     = busy && memory_ack_i;
    assign timeout_hit = busy && !memory_ack_i && cyc_held && (wait_q == TO_LAST);
    assign abandon     = busy && !memory_ack_i && !cyc_held;

    // State, owner, round-robin pointer and wait counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= 3'b000;
            gidx_q  <= 2'd0;
            last_q  <= 2'd2;
            wait_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state logic: arbitrate in IDLE, and watch for the end of the transaction in BUSY.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE: begin
                if (|pending) begin
                    gidx_d  = rr_pick(last_q, pending);
                    grant_d = 3'b001 << gidx_d;
                    wait_d  = 16'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (ack_hit || timeout_hit || abandon) begin
                    state_d = IDLE;
                    grant_d = 3'b000;
                    last_d  = gidx_q;
                end else begin
                    wait_d = 16'(wait_q + 16'd1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 3'b000;
            end
        endcase
    end

    // Memory-side mux: the owner's request passes straight through while BUSY; otherwise zero.
    always_comb begin
        memory_we_o   = 1'b0;
        memory_addr_o = '0;
        memory_mosi_o = '0;
        for (int n = 0; n < 3; n++) begin
            if (busy && grant_q[n]) begin
                memory_we_o   = req_we_i[n];
                memory_addr_o = req_addr_i[n*ADDR_WIDTH +: ADDR_WIDTH];
                memory_mosi_o = req_mosi_i[n*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    // Requester-side demux: only the owner sees the ack, error and read data.
    always_comb begin
        req_miso_o = '0;
        for (int n = 0; n < 3; n++) begin
            if (ack_hit && grant_q[n]) begin
                req_miso_o[n*WORD_SIZE +: WORD_SIZE] = memory_miso_i;
            end
        end
    end

    assign memory_cyc_o = busy && cyc_held;
    assign memory_stb_o = busy && cyc_held;
    assign req_ack_o    = ack_hit     ? grant_q : 3'b000;
    assign req_err_o    = timeout_hit ? grant_q : 3'b000;
    assign grant_o      = grant_q;

endmodule
